// File: rtl/ycbcr_pkg.sv
// Sequencer state encoding and byte-order constants shared by the YCbCr packer.
// YCBCR_PACKER_UYVY_EN selects Cb,Y0,Cr,Y1 ordering; the default is Y0,Cb,Y1,Cr.
package ycbcr_pkg;

    typedef enum logic [1:0] {
        S_Y0 = 2'd0,
        S_CB = 2'd1,
        S_Y1 = 2'd2,
        S_CR = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } chan_sel_t;

`ifdef YCBCR_PACKER_UYVY_EN
    localparam seq_state_t SEQ_FIRST = S_CB;
`else
    localparam seq_state_t SEQ_FIRST = S_Y0;
`endif

    function automatic seq_state_t seq_next(input seq_state_t s);
`ifdef YCBCR_PACKER_UYVY_EN
        case (s)
            S_CB:    return S_Y0;
            S_Y0:    return S_CR;
            S_CR:    return S_Y1;
            default: return S_CB;
        endcase
`else
        case (s)
            S_Y0:    return S_CB;
            S_CB:    return S_Y1;
            S_Y1:    return S_CR;
            default: return S_Y0;
        endcase
`endif
    endfunction

    function automatic chan_sel_t seq_chan(input seq_state_t s);
        case (s)
            S_CB:    return CH_CB;
            S_CR:    return CH_CR;
            default: return CH_Y;
        endcase
    endfunction

endpackage

// File: rtl/ycbcr_chan_fifo.sv
// Per-channel sample FIFO, DEPTH x 8, with synchronous flush.
// Latency: write visible at the read port one cycle after the write edge.
// Backpressure: writes are dropped while full; full is registered, so there is no pass-through.
module ycbcr_chan_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ycbcr_packer.sv
// Interleaves Y/Cb/Cr sample streams into a 4:2:2 byte stream with frame/line markers.
// Latency: a sample written into an empty path appears on pixel_out one edge later.
// Backpressure: output holds while pixel_ready=0; channels stall via FIFO-full ready. Order set by YCBCR_PACKER_UYVY_EN.
module ycbcr_packer
    import ycbcr_pkg::*;
#(
    parameter int LINE_WIDTH  = 320,
    parameter int FRAME_LINES = 240,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       restart,
    input  logic [7:0] y_data,
    input  logic [7:0] cb_data,
    input  logic [7:0] cr_data,
    input  logic       y_valid,
    input  logic       cb_valid,
    input  logic       cr_valid,
    output logic       y_ready,
    output logic       cb_ready,
    output logic       cr_ready,
    output logic [7:0] pixel_out,
    output logic       pixel_valid,
    input  logic       pixel_ready,
    output logic       frame_start,
    output logic       line_start,
    output logic       line_end,
    output logic       packing_active
);
    localparam int COL_W  = $clog2(2 * LINE_WIDTH);
    localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(2 * LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    seq_state_t        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [7:0]        pix_q, pix_d;
    logic              vld_q, vld_d;
    logic              fs_q, fs_d, ls_q, ls_d, le_q, le_d;
    logic              last_q, last_d;
    logic              active_q, active_d;

    logic       y_full, y_empty, cb_full, cb_empty, cr_full, cr_empty;
    logic [7:0] y_rd, cb_rd, cr_rd, sel_data;
    chan_sel_t  chan;
    logic       avail, load, accept, col_last, line_last, first_byte;

    ycbcr_chan_fifo #(.DEPTH(FIFO_DEPTH)) u_y_fifo (
        .clk(clk), .rst(rst), .flush(restart),
        .wr_en(y_valid), .wr_data(y_data), .rd_en(load && (chan == CH_Y)),
        .rd_data(y_rd), .full(y_full), .empty(y_empty)
    );
    ycbcr_chan_fifo #(.DEPTH(FIFO_DEPTH)) u_cb_fifo (
        .clk(clk), .rst(rst), .flush(restart),
        .wr_en(cb_valid), .wr_data(cb_data), .rd_en(load && (chan == CH_CB)),
        .rd_data(cb_rd), .full(cb_full), .empty(cb_empty)
    );
    ycbcr_chan_fifo #(.DEPTH(FIFO_DEPTH)) u_cr_fifo (
        .clk(clk), .rst(rst), .flush(restart),
        .wr_en(cr_valid), .wr_data(cr_data), .rd_en(load && (chan == CH_CR)),
        .rd_data(cr_rd), .full(cr_full), .empty(cr_empty)
    );

    assign y_ready  = !y_full;
    assign cb_ready = !cb_full;
    assign cr_ready = !cr_full;

    always_comb begin
        chan       = seq_chan(state_q);
        avail      = !y_empty;
        sel_data   = y_rd;
        case (chan)
            CH_CB:   begin avail = !cb_empty; sel_data = cb_rd; end
            CH_CR:   begin avail = !cr_empty; sel_data = cr_rd; end
            default: begin avail = !y_empty;  sel_data = y_rd;  end
        endcase
        accept     = vld_q && pixel_ready;
        load       = enable && avail && (!vld_q || pixel_ready);
        col_last   = (col_q == COL_LAST);
        line_last  = (line_q == LINE_LAST);
        first_byte = (col_q == '0) && (line_q == '0);

        state_d  = state_q;
        col_d    = col_q;
        line_d   = line_q;
        pix_d    = pix_q;
        vld_d    = vld_q;
        fs_d     = fs_q;
        ls_d     = ls_q;
        le_d     = le_q;
        last_d   = last_q;
        active_d = active_q;

        if (load) begin
            pix_d  = sel_data;
            vld_d  = 1'b1;
            fs_d   = first_byte;
            ls_d   = (col_q == '0);
            le_d   = col_last;
            last_d = col_last && line_last;
            // Re-anchor the sequencer on every line so a line always opens with the first byte kind.
            state_d = col_last ? SEQ_FIRST : seq_next(state_q);
            col_d   = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                line_d = line_last ? '0 : line_q + LINE_W'(1);
            end
        end else if (accept) begin
            vld_d = 1'b0;
        end

        if (accept && last_q) begin
            active_d = 1'b0;
        end
        if (load && first_byte) begin
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_q  <= SEQ_FIRST;
            col_q    <= '0;
            line_q   <= '0;
            pix_q    <= '0;
            vld_q    <= 1'b0;
            fs_q     <= 1'b0;
            ls_q     <= 1'b0;
            le_q     <= 1'b0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            line_q   <= line_d;
            pix_q    <= pix_d;
            vld_q    <= vld_d;
            fs_q     <= fs_d;
            ls_q     <= ls_d;
            le_q     <= le_d;
            last_q   <= last_d;
            active_q <= active_d;
        end
    end

    assign pixel_out      = pix_q;
    assign pixel_valid    = vld_q;
    assign frame_start    = fs_q;
    assign line_start     = ls_q;
    assign line_end       = le_q;
    assign packing_active = active_q;

endmodule

// File: tb/tb_ycbcr_packer.sv
// Directed bench for ycbcr_packer (LINE_WIDTH=4, FRAME_LINES=2); byte order follows YCBCR_PACKER_UYVY_EN.
`timescale 1ns/1ps
module tb_ycbcr_packer;
`ifdef YCBCR_PACKER_UYVY_EN
    localparam bit UYVY = 1'b1;
`else
    localparam bit UYVY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, enable, restart;
    logic [7:0] y_data, cb_data, cr_data;
    logic       y_valid, cb_valid, cr_valid;
    logic       y_ready, cb_ready, cr_ready;
    logic [7:0] pixel_out;
    logic       pixel_valid, pixel_ready;
    logic       frame_start, line_start, line_end, packing_active;

    int checks = 0;
    int errors = 0;
    logic [10:0] mon_q [$];
    logic [7:0]  exp_b [8];

    ycbcr_packer #(.LINE_WIDTH(4), .FRAME_LINES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .y_data(y_data), .cb_data(cb_data), .cr_data(cr_data),
        .y_valid(y_valid), .cb_valid(cb_valid), .cr_valid(cr_valid),
        .y_ready(y_ready), .cb_ready(cb_ready), .cr_ready(cr_ready),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .frame_start(frame_start), .line_start(line_start), .line_end(line_end),
        .packing_active(packing_active)
    );

    always #5 clk = ~clk;

    // Record every byte that the next rising edge will accept, with its markers.
    always @(negedge clk) begin
        if (pixel_valid && pixel_ready)
            mon_q.push_back({frame_start, line_start, line_end, pixel_out});
    end

    task automatic drive_cycle(input logic yv, input logic [7:0] yd, input logic cbv,
                               input logic [7:0] cbd, input logic crv, input logic [7:0] crd);
        y_valid = yv; y_data = yd; cb_valid = cbv; cb_data = cbd; cr_valid = crv; cr_data = crd;
        @(posedge clk); #1;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        mon_q.delete();
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 80 && mon_q.size() < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pixel_valid); end
        checks++; if (pixel_out !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", pixel_out); end
        checks++; if ({frame_start, line_start, line_end} !== 3'b000) begin errors++; $display("FAIL reset_markers: got %b expected 000", {frame_start, line_start, line_end}); end
        checks++; if (packing_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", packing_active); end
        checks++; if ({y_ready, cb_ready, cr_ready} !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected 111", {y_ready, cb_ready, cr_ready}); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        logic [10:0] e;
        do_restart();
        pixel_ready = 1'b1; enable = 1'b1;
        drive_cycle(1'b1, 8'd10, 1'b1, 8'd20, 1'b1, 8'd30);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid %b expected 0", pixel_valid); end
        drive_cycle(1'b1, 8'd11, 1'b1, 8'd21, 1'b1, 8'd31);
        checks++; if (pixel_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", pixel_valid); end
        checks++; if (pixel_out !== exp_b[0]) begin errors++; $display("FAIL latency_byte: got %0d expected %0d", pixel_out, exp_b[0]); end
        drive_cycle(1'b1, 8'd12, 1'b0, 8'd0, 1'b0, 8'd0);
        drive_cycle(1'b1, 8'd13, 1'b0, 8'd0, 1'b0, 8'd0);
        wait_bytes(8);
        checks++;
        if (mon_q.size() < 8) begin
            errors++; $display("FAIL basic_timeout: got %0d bytes expected 8", mon_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                e = mon_q[i];
                checks++; if (e[7:0] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %0d expected %0d", i, e[7:0], exp_b[i]); end
                checks++; if (e[10:8] !== {i == 0, i == 0, i == 7}) begin errors++; $display("FAIL basic_mark%0d: got %b expected %b", i, e[10:8], {i == 0, i == 0, i == 7}); end
            end
        end
    endtask

    task automatic test_enable();
        do_restart();
        pixel_ready = 1'b1; enable = 1'b0;
        drive_cycle(1'b1, 8'd10, 1'b1, 8'd20, 1'b1, 8'd30);
        idle(4);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL enable_block: got valid %b expected 0", pixel_valid); end
        enable = 1'b1;
        idle(1);
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== exp_b[0]) begin errors++; $display("FAIL enable_load: got %b/%0d expected 1/%0d", pixel_valid, pixel_out, exp_b[0]); end
        enable = 1'b0;
        idle(1);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL enable_drain: got valid %b expected 0", pixel_valid); end
        enable = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [7:0] ys [3];
        logic [10:0] e;
        ys[0] = 8'd13; ys[1] = 8'd14; ys[2] = 8'd15;
        do_restart();
        pixel_ready = 1'b0; enable = 1'b1;
        drive_cycle(1'b1, 8'd10, 1'b1, 8'd20, 1'b1, 8'd30);
        drive_cycle(1'b1, 8'd11, 1'b0, 8'd0, 1'b0, 8'd0);
        checks++; if (pixel_out !== exp_b[0]) begin errors++; $display("FAIL bp_first: got %0d expected %0d", pixel_out, exp_b[0]); end
        pixel_ready = 1'b1;
        drive_cycle(1'b1, 8'd12, 1'b0, 8'd0, 1'b0, 8'd0);
        pixel_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive_cycle(1'b1, ys[s], s == 0, 8'd21, s == 0, 8'd31);
            checks++; if (pixel_valid !== 1'b1 || pixel_out !== exp_b[1]) begin errors++; $display("FAIL bp_hold%0d: got %b/%0d expected 1/%0d", s, pixel_valid, pixel_out, exp_b[1]); end
            if (s > 0) begin
                checks++; if (y_ready !== 1'b0) begin errors++; $display("FAIL bp_yfull%0d: got y_ready %b expected 0", s, y_ready); end
            end
        end
        pixel_ready = 1'b1;
        wait_bytes(8);
        checks++;
        if (mon_q.size() < 8) begin
            errors++; $display("FAIL bp_timeout: got %0d bytes expected 8", mon_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                e = mon_q[i];
                checks++; if (e[7:0] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d: got %0d expected %0d", i, e[7:0], exp_b[i]); end
            end
        end
        checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got y_ready %b expected 1", y_ready); end
    endtask

    task automatic test_cb_starve();
        int cbpos;
        logic [10:0] e;
        cbpos = UYVY ? 0 : 1;
        do_restart();
        pixel_ready = 1'b1; enable = 1'b1;
        drive_cycle(1'b1, 8'd10, 1'b0, 8'd0, 1'b1, 8'd30);
        drive_cycle(1'b1, 8'd11, 1'b0, 8'd0, 1'b0, 8'd0);
        idle(6);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL starve_valid: got %b expected 0", pixel_valid); end
        checks++; if (mon_q.size() != cbpos) begin errors++; $display("FAIL starve_count: got %0d bytes expected %0d", mon_q.size(), cbpos); end
        drive_cycle(1'b0, 8'd0, 1'b1, 8'd20, 1'b0, 8'd0);
        wait_bytes(cbpos + 2);
        checks++;
        if (mon_q.size() < cbpos + 2) begin
            errors++; $display("FAIL starve_timeout: got %0d bytes expected %0d", mon_q.size(), cbpos + 2);
        end else begin
            e = mon_q[cbpos];
            checks++; if (e[7:0] !== 8'd20) begin errors++; $display("FAIL starve_cb: got %0d expected 20", e[7:0]); end
            e = mon_q[cbpos + 1];
            checks++; if (e[7:0] !== exp_b[cbpos + 1]) begin errors++; $display("FAIL starve_next: got %0d expected %0d", e[7:0], exp_b[cbpos + 1]); end
        end
    endtask

    task automatic test_frame();
        int yi, cbi, cri, nfs, nls, nle;
        bit mid_done;
        logic [10:0] e;
        yi = 0; cbi = 0; cri = 0; mid_done = 1'b0;
        do_restart();
        pixel_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 200 && mon_q.size() < 16; c++) begin
            y_valid  = (yi < 8) && y_ready;   y_data  = 8'(100 + yi);
            cb_valid = (cbi < 4) && cb_ready; cb_data = 8'(120 + cbi);
            cr_valid = (cri < 4) && cr_ready; cr_data = 8'(140 + cri);
            @(posedge clk);
            if (y_valid) yi++;
            if (cb_valid) cbi++;
            if (cr_valid) cri++;
            #1;
            if (!mid_done && mon_q.size() >= 8) begin
                mid_done = 1'b1;
                checks++; if (packing_active !== 1'b1) begin errors++; $display("FAIL frame_mid_active: got %b expected 1", packing_active); end
            end
        end
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        checks++;
        if (mon_q.size() < 16) begin
            errors++; $display("FAIL frame_timeout: got %0d bytes expected 16", mon_q.size());
        end else begin
            checks++; if (packing_active !== 1'b0) begin errors++; $display("FAIL frame_end_active: got %b expected 0", packing_active); end
            nfs = 0; nls = 0; nle = 0;
            for (int i = 0; i < 16; i++) begin
                e = mon_q[i];
                nfs += int'(e[10]); nls += int'(e[9]); nle += int'(e[8]);
            end
            checks++; if (nfs != 1) begin errors++; $display("FAIL frame_fs_count: got %0d expected 1", nfs); end
            checks++; if (nls != 2) begin errors++; $display("FAIL frame_ls_count: got %0d expected 2", nls); end
            checks++; if (nle != 2) begin errors++; $display("FAIL frame_le_count: got %0d expected 2", nle); end
            e = mon_q[8];
            checks++; if (e[10:9] !== 2'b01) begin errors++; $display("FAIL frame_line1_mark: got %b expected 01", e[10:9]); end
            e = mon_q[15];
            checks++; if (e[7:0] !== (UYVY ? 8'd107 : 8'd143)) begin errors++; $display("FAIL frame_last_byte: got %0d expected %0d", e[7:0], UYVY ? 107 : 143); end
        end
    endtask

    task automatic test_restart();
        logic [10:0] e;
        do_restart();
        pixel_ready = 1'b0; enable = 1'b1;
        drive_cycle(1'b1, 8'd10, 1'b1, 8'd20, 1'b1, 8'd30);
        drive_cycle(1'b1, 8'd11, 1'b1, 8'd21, 1'b1, 8'd31);
        drive_cycle(1'b1, 8'd12, 1'b0, 8'd0, 1'b0, 8'd0);
        drive_cycle(1'b1, 8'd13, 1'b0, 8'd0, 1'b0, 8'd0);
        pixel_ready = 1'b1;
        wait_bytes(5);
        checks++; if (mon_q.size() < 5) begin errors++; $display("FAIL restart_prefill: got %0d bytes expected 5", mon_q.size()); end
        do_restart();
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL restart_valid: got %b expected 0", pixel_valid); end
        checks++; if ({y_ready, cb_ready, cr_ready} !== 3'b111) begin errors++; $display("FAIL restart_ready: got %b expected 111", {y_ready, cb_ready, cr_ready}); end
        checks++; if (packing_active !== 1'b0) begin errors++; $display("FAIL restart_active: got %b expected 0", packing_active); end
        drive_cycle(1'b1, 8'd40, 1'b1, 8'd50, 1'b1, 8'd60);
        wait_bytes(1);
        checks++;
        if (mon_q.size() < 1) begin
            errors++; $display("FAIL restart_timeout: got 0 bytes expected 1");
        end else begin
            e = mon_q[0];
            checks++; if (e[10:9] !== 2'b11) begin errors++; $display("FAIL restart_fs: got %b expected 11", e[10:9]); end
            checks++; if (e[7:0] !== (UYVY ? 8'd50 : 8'd40)) begin errors++; $display("FAIL restart_byte: got %0d expected %0d", e[7:0], UYVY ? 50 : 40); end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; restart = 1'b0; pixel_ready = 1'b0;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        y_data = 8'd0; cb_data = 8'd0; cr_data = 8'd0;
        if (UYVY) begin
            exp_b[0] = 8'd20; exp_b[1] = 8'd10; exp_b[2] = 8'd30; exp_b[3] = 8'd11;
            exp_b[4] = 8'd21; exp_b[5] = 8'd12; exp_b[6] = 8'd31; exp_b[7] = 8'd13;
        end else begin
            exp_b[0] = 8'd10; exp_b[1] = 8'd20; exp_b[2] = 8'd11; exp_b[3] = 8'd30;
            exp_b[4] = 8'd12; exp_b[5] = 8'd21; exp_b[6] = 8'd13; exp_b[7] = 8'd31;
        end
        test_reset();
        test_basic();
        test_enable();
        test_backpressure();
        test_cb_starve();
        test_frame();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
